uart_tx_feeder: RTL and testbench

- Byte buffer and launch controller that sits directly upstream of the UART transmitter FSM/serializer.
- Accepts bytes from the system side into a small synchronous FIFO.
- Launches one byte at a time into the transmitter: one-cycle valid pulse plus held parallel data.
- Tracks the transmitter's busy flag so a new frame starts only after the previous frame has fully left the line.

---
 rtl/uart_tx_feeder.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller feeding a UART transmitter.
// Bytes queue from the system side; one is launched per frame.
//
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   wr_data, wr_en      : enqueue interface
//   fifo_full/empty     : registered occupancy flags
//   fifo_count          : registered number of stored bytes
//   wr_drop             : pulse, a write hit a full FIFO
//   tx_busy             : busy flag from the transmitter FSM
//   tx_valid, tx_data   : launch pulse and held parallel byte
//   tx_err              : pulse, tx_busy never rose after a launch
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  wr_drop,
    input  logic                  tx_busy,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_err
);

    localparam int CW  = ADDR_WIDTH + 1;
    localparam int WCW = $clog2(BUSY_WAIT + 1);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [WCW-1:0]        WAIT_ONE = WCW'(1);
    localparam logic [WCW-1:0]        WAIT_LST = WCW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    // Storage (never reset)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // FIFO bookkeeping
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  drop_q, drop_d;

    // Launch FSM
    state_e                state_q, state_d;
    logic [WCW-1:0]        wait_q, wait_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic wr_acc;
    logic rd_en;

    // Full is judged on the pre-edge flag, so a pop on the
    // same edge cannot rescue a write into a full FIFO.
    assign wr_acc = wr_en & ~full_q;

    // ---------------------------------------------------------
    // Launch FSM next-state and outputs
    // ---------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        rd_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty_q && !tx_busy) begin
                    data_d  = mem_q[rd_ptr_q];
                    valid_d = 1'b1;
                    rd_en   = 1'b1;
                    wait_d  = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_q == WAIT_LST) begin
                    // Counter reaches BUSY_WAIT on this edge:
                    // give up on the byte.
                    wait_d  = wait_q + WAIT_ONE;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_ONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Corrupt encoding: park with outputs cleared.
                state_d = IDLE;
                wait_d  = '0;
                data_d  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------
    // FIFO next-state
    // ---------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = wr_en & full_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // ---------------------------------------------------------
    // Registers
    // ---------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
            state_q  <= IDLE;
            wait_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            wait_q   <= wait_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_count = count_q;
    assign wr_drop    = drop_q;
    assign tx_valid   = valid_q;
    assign tx_data    = data_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small
// transmitter model driving tx_busy.
module tb_uart_tx_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       wr_drop;
    logic       tx_busy;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_err;

    int total = 0;
    int bad   = 0;

    // Transmitter model controls
    logic       model_en = 1'b0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    int         overlap  = 0;
    logic [7:0] rxq[$];

    uart_tx_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .wr_drop    (wr_drop),
        .tx_busy    (tx_busy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_err     (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Monitor + transmitter model, 2 time units after each edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_valid === 1'b1) begin
                rxq.push_back(tx_data);
            end
            if (model_en) begin
                if (tx_valid === 1'b1) begin
                    if (tx_busy) overlap++;
                    busy_cnt = busy_len;
                    tx_busy  = 1'b1;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_err", tx_err, 0);
        chk("rst_drop", wr_drop, 0);

        // Single byte, busy for 10 cycles
        model_en = 1'b1;
        busy_len = 10;
        rxq.delete();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("one_cnt", fifo_count, 1);
        chk("one_empty", fifo_empty, 0);
        chk("one_val0", tx_valid, 0);
        step();
        chk("one_valid", tx_valid, 1);
        chk("one_data", tx_data, 8'hA5);
        chk("one_empty2", fifo_empty, 1);
        step();
        chk("one_pulse", tx_valid, 0);
        chk("one_hold", tx_data, 8'hA5);
        for (int i = 0; i < 12; i++) step();
        chk("one_nvalid", rxq.size(), 1);
        chk("one_hold2", tx_data, 8'hA5);
        chk("one_busy", tx_busy, 0);

        // Burst of 10 into a busy transmitter
        model_en = 1'b0;
        tx_busy  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        chk("bst_full", fifo_full, 1);
        chk("bst_cnt8", fifo_count, 8);
        chk("bst_nodrop", wr_drop, 0);
        wr_data = 8'h09;
        step();
        chk("bst_drop9", wr_drop, 1);
        wr_data = 8'h0A;
        step();
        chk("bst_dropA", wr_drop, 1);
        chk("bst_cnt", fifo_count, 8);
        wr_en = 1'b0;
        step();
        chk("bst_drop0", wr_drop, 0);
        rxq.delete();
        busy_len = 12;
        tx_busy  = 1'b0;
        model_en = 1'b1;
        for (int i = 0; i < 200 && rxq.size() < 8; i++)
            step();
        chk("bst_nrx", rxq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rxq.size())
                chk($sformatf("bst_rx%0d", i), rxq[i], i + 1);
        end
        for (int i = 0; i < 16; i++) step();
        chk("bst_empty", fifo_empty, 1);
        chk("bst_cnt0", fifo_count, 0);

        // Simultaneous read and write
        model_en = 1'b0;
        tx_busy  = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hB1;
        step();
        wr_data  = 8'hB2;
        step();
        chk("rw_pre", fifo_count, 2);
        rxq.delete();
        busy_len = 3;
        model_en = 1'b1;
        tx_busy  = 1'b0;
        wr_data  = 8'hB3;
        step();
        wr_en = 1'b0;
        chk("rw_cnt", fifo_count, 2);
        chk("rw_valid", tx_valid, 1);
        chk("rw_data", tx_data, 8'hB1);
        for (int i = 0; i < 60 && rxq.size() < 3; i++)
            step();
        chk("rw_nrx", rxq.size(), 3);
        if (rxq.size() == 3) begin
            chk("rw_rx0", rxq[0], 8'hB1);
            chk("rw_rx1", rxq[1], 8'hB2);
            chk("rw_rx2", rxq[2], 8'hB3);
        end
        for (int i = 0; i < 8; i++) step();
        chk("no_overlap", overlap, 0);

        // Busy timeout
        model_en = 1'b0;
        tx_busy  = 1'b0;
        wr_en    = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_en = 1'b0;
        step();
        chk("to_valid", tx_valid, 1);
        chk("to_data", tx_data, 8'h3C);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("to_err_l%0d", i), tx_err, 0);
            chk($sformatf("to_val_l%0d", i), tx_valid, 0);
        end
        step();
        chk("to_err", tx_err, 1);
        chk("to_hold", tx_data, 8'h3C);
        wr_en   = 1'b1;
        wr_data = 8'h3D;
        step();
        wr_en = 1'b0;
        chk("to_err_end", tx_err, 0);
        chk("to_cnt", fifo_count, 1);
        step();
        chk("to_next_v", tx_valid, 1);
        chk("to_next_d", tx_data, 8'h3D);
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        step();
        chk("to_no_err", tx_err, 0);
        tx_busy = 1'b1;

        // Full boundary with a pop on the same edge
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            step();
        end
        chk("fb_full", fifo_full, 1);
        chk("fb_nolaunch", tx_valid, 0);
        tx_busy = 1'b0;
        wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        chk("fb_drop", wr_drop, 1);
        chk("fb_cnt", fifo_count, 7);
        chk("fb_full0", fifo_full, 0);
        chk("fb_valid", tx_valid, 1);
        chk("fb_data", tx_data, 8'h60);

        // Reset mid-frame with bytes queued
        tx_busy = 1'b1;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("mr_cnt", fifo_count, 0);
        chk("mr_empty", fifo_empty, 1);
        chk("mr_valid", tx_valid, 0);
        chk("mr_data", tx_data, 8'h00);
        chk("mr_drop", wr_drop, 0);
        tx_busy = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        chk("mr_launch", tx_valid, 1);
        chk("mr_ldata", tx_data, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
